// File: rtl/serial_frame_ctrl.sv
// serial_frame_ctrl: nibble frame aligner with lock hysteresis and a 1-deep payload buffer.
module serial_frame_ctrl #(
    parameter logic [3:0] SYNC_WORD = 4'b1011,
    parameter int         LOCK_CNT  = 2,
    parameter int         LOSS_CNT  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       srl,
    input  logic       srl_en,
    output logic [1:0] ParaSig1,
    output logic [1:0] ParaSig2,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       locked,
    output logic       overflow,
    output logic [7:0] frame_cnt
);
    typedef enum logic [1:0] {HUNT, DATA, CHECK} state_t;
    localparam logic [2:0] LOCK_N = 3'(LOCK_CNT);
    localparam logic [2:0] LOSS_N = 3'(LOSS_CNT);
    state_t     state;
    logic [3:0] sh;
    logic [1:0] bc;
    logic [2:0] good_cnt;
    logic [2:0] miss_cnt;
    logic [3:0] sh_n;
    logic       last;
    logic       sync_ok;
    logic       load;
    assign sh_n    = {srl, sh[3:1]};
    assign last    = bc == 2'd3;
    assign sync_ok = sh_n == SYNC_WORD;
    // only payloads captured while already locked reach the buffer
    assign load    = srl_en && state == DATA && last && locked;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= HUNT;
            sh        <= '0;
            bc        <= '0;
            good_cnt  <= '0;
            miss_cnt  <= '0;
            ParaSig1  <= '0;
            ParaSig2  <= '0;
            out_valid <= 1'b0;
            locked    <= 1'b0;
            overflow  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (good_cnt >= LOCK_N) locked <= 1'b1;
            if (srl_en) begin
                sh <= sh_n;
                bc <= bc + 2'd1;
                case (state)
                    HUNT: if (sync_ok) begin
                        good_cnt <= 3'd1;
                        bc       <= '0;
                        state    <= DATA;
                    end
                    DATA: if (last) state <= CHECK;
                    CHECK: if (last) begin
                        if (sync_ok) begin
                            good_cnt <= (good_cnt == 3'd7) ? 3'd7 : good_cnt + 3'd1;
                            miss_cnt <= '0;
                            state    <= DATA;
                        end else if (!locked) begin
                            good_cnt <= '0;
                            state    <= HUNT;
                        end else if (miss_cnt + 3'd1 == LOSS_N) begin
                            locked   <= 1'b0;
                            good_cnt <= '0;
                            miss_cnt <= '0;
                            state    <= HUNT;
                        end else begin
                            miss_cnt <= miss_cnt + 3'd1;
                            state    <= DATA;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
            if (load && (!out_valid || out_ready)) begin
                ParaSig1  <= {sh_n[3], sh_n[1]};
                ParaSig2  <= {sh_n[2], sh_n[0]};
                out_valid <= 1'b1;
                frame_cnt <= frame_cnt + 8'd1;
            end else if (load) begin
                overflow <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_serial_frame_ctrl.sv
// tb_serial_frame_ctrl: directed vectors with hand-computed expectations for serial_frame_ctrl.
module tb_serial_frame_ctrl;
    logic       clk = 1'b0, rst = 1'b0, srl = 1'b0, srl_en = 1'b0, out_ready = 1'b0;
    logic [1:0] ParaSig1, ParaSig2;
    logic       out_valid, locked, overflow;
    logic [7:0] frame_cnt;
    int         n_vec = 0, n_err = 0;
    always #5 clk = ~clk;
    serial_frame_ctrl dut (
        .clk(clk), .rst(rst), .srl(srl), .srl_en(srl_en),
        .ParaSig1(ParaSig1), .ParaSig2(ParaSig2), .out_valid(out_valid),
        .out_ready(out_ready), .locked(locked), .overflow(overflow), .frame_cnt(frame_cnt)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        srl_en = 1'b0;
        tick();
    endtask
    task automatic send_bit(input logic b, input bit gap);
        if (gap) begin
            srl_en = 1'b0;
            srl = ~b;
            tick();
        end
        srl = b;
        srl_en = 1'b1;
        tick();
        srl_en = 1'b0;
    endtask
    task automatic send_nib(input logic [3:0] v, input bit gap);
        for (int i = 0; i < 4; i++) send_bit(v[i], gap);
    endtask
    task automatic do_reset(input string tag);
        rst = 1'b0;
        srl = 1'b1;
        srl_en = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b1;
        srl_en = 1'b0;
        chk({tag, ".locked"}, 32'(locked), 0);
        chk({tag, ".valid"}, 32'(out_valid), 0);
        chk({tag, ".p1"}, 32'(ParaSig1), 0);
        chk({tag, ".p2"}, 32'(ParaSig2), 0);
        chk({tag, ".ovf"}, 32'(overflow), 0);
        chk({tag, ".cnt"}, 32'(frame_cnt), 0);
        chk({tag, ".state"}, 32'(dut.state), 0);
    endtask
    task automatic run_lock(input bit gap, input string tag);
        out_ready = 1'b1;
        send_nib(4'b1011, gap);
        send_nib(4'b0110, gap);
        chk({tag, ".unlk_drop_valid"}, 32'(out_valid), 0);
        chk({tag, ".unlk_drop_cnt"}, 32'(frame_cnt), 0);
        send_nib(4'b1011, gap);
        chk({tag, ".locked_b12"}, 32'(locked), 0);
        idle();
        chk({tag, ".locked_b12p1"}, 32'(locked), 1);
        send_nib(4'b0110, gap);
        chk({tag, ".valid"}, 32'(out_valid), 1);
        chk({tag, ".p1"}, 32'(ParaSig1), 32'h1);
        chk({tag, ".p2"}, 32'(ParaSig2), 32'h2);
        chk({tag, ".cnt"}, 32'(frame_cnt), 1);
        idle();
        chk({tag, ".xfer_valid"}, 32'(out_valid), 0);
        chk({tag, ".xfer_cnt"}, 32'(frame_cnt), 1);
    endtask
    initial begin
        do_reset("rst0");
        run_lock(1'b0, "lock");
        // backpressure: payload A = 1100 held, payload B = 0011 dropped
        out_ready = 1'b0;
        send_nib(4'b1011, 1'b0);
        send_nib(4'b1100, 1'b0);
        chk("bp.a_valid", 32'(out_valid), 1);
        chk("bp.a_p1", 32'(ParaSig1), 32'h2);
        chk("bp.a_p2", 32'(ParaSig2), 32'h2);
        chk("bp.a_cnt", 32'(frame_cnt), 2);
        chk("bp.a_ovf", 32'(overflow), 0);
        send_nib(4'b1011, 1'b0);
        send_nib(4'b0011, 1'b0);
        chk("bp.b_valid", 32'(out_valid), 1);
        chk("bp.b_p1", 32'(ParaSig1), 32'h2);
        chk("bp.b_p2", 32'(ParaSig2), 32'h2);
        chk("bp.b_ovf", 32'(overflow), 1);
        chk("bp.b_cnt", 32'(frame_cnt), 2);
        out_ready = 1'b1;
        idle();
        chk("bp.rel_valid", 32'(out_valid), 0);
        chk("bp.rel_ovf", 32'(overflow), 1);
        do_reset("rst1");
        // loss of lock with hysteresis
        send_nib(4'b1011, 1'b0);
        send_nib(4'b0110, 1'b0);
        send_nib(4'b1011, 1'b0);
        idle();
        chk("loss.locked0", 32'(locked), 1);
        for (int i = 0; i < 2; i++) begin
            send_nib(4'b0110, 1'b0);
            send_nib(4'b0000, 1'b0);
        end
        send_nib(4'b0110, 1'b0);
        send_nib(4'b1011, 1'b0);
        chk("loss.2bad1good_locked", 32'(locked), 1);
        chk("loss.2bad1good_cnt", 32'(frame_cnt), 3);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) out_ready = 1'b0;
            send_nib(i == 2 ? 4'b1100 : 4'b0110, 1'b0);
            send_nib(4'b0000, 1'b0);
            if (i == 1) chk("loss.2bad_locked", 32'(locked), 1);
        end
        chk("loss.3bad_locked", 32'(locked), 0);
        chk("loss.3bad_state", 32'(dut.state), 0);
        chk("loss.keep_valid", 32'(out_valid), 1);
        chk("loss.keep_p1", 32'(ParaSig1), 32'h2);
        chk("loss.cnt", 32'(frame_cnt), 6);
        out_ready = 1'b1;
        idle();
        chk("loss.drain_valid", 32'(out_valid), 0);
        do_reset("rst2");
        run_lock(1'b1, "gap");
        // reset mid-frame after bit 10
        do_reset("rst3");
        send_nib(4'b1011, 1'b0);
        send_nib(4'b0110, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        do_reset("mid");
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_nib(4'b0000, 1'b0);
        idle();
        chk("mid.locked", 32'(locked), 0);
        run_lock(1'b0, "relock");
        // frame counter wrap
        do_reset("rst4");
        send_nib(4'b1011, 1'b0);
        send_nib(4'b0110, 1'b0);
        send_nib(4'b1011, 1'b0);
        for (int i = 0; i < 256; i++) begin
            send_nib(4'b0110, 1'b0);
            if (i == 254) chk("wrap.cnt255", 32'(frame_cnt), 255);
            send_nib(4'b1011, 1'b0);
        end
        chk("wrap.cnt0", 32'(frame_cnt), 0);
        chk("wrap.ovf", 32'(overflow), 0);
        chk("wrap.locked", 32'(locked), 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
